// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX line encoder.
// Macro TX_LOW_SPEED_EN selects low-speed J polarity (D+ 0 / D- 1); default is full-speed.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    STUFF   = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_enc_state_t;

`ifdef TX_LOW_SPEED_EN
  localparam logic J_DP = 1'b0;
  localparam logic J_DM = 1'b1;
`else
  localparam logic J_DP = 1'b1;
  localparam logic J_DM = 1'b0;
`endif

  localparam logic SE0_DP = 1'b0;
  localparam logic SE0_DM = 1'b0;

  localparam int unsigned DEF_STUFF_LIMIT  = 6;
  localparam int unsigned DEF_EOP_SE0_BITS = 2;
  localparam int unsigned DEF_EOP_J_BITS   = 1;

endpackage

// File: rtl/usb_tx_bit_stuffer.sv
// Run-length counter of consecutive 1s; flags when accepting another 1 reaches the stuff limit.
module usb_tx_bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic one_accept,
  input  logic clear,
  output logic stuff_req
);

  localparam int unsigned CW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(STUFF_LIMIT);

  logic [CW-1:0] ones_cnt_q;
  logic [CW-1:0] ones_cnt_d;
  logic [CW:0]   ones_next;

  // stuff_req looks ahead: it is high when the 1 being accepted now completes the run.
  always_comb begin
    ones_next  = {1'b0, ones_cnt_q} + {{CW{1'b0}}, 1'b1};
    stuff_req  = (ones_next == LIMIT);
    ones_cnt_d = ones_cnt_q;
    if (clear) begin
      ones_cnt_d = '0;
    end else if (one_accept) begin
      ones_cnt_d = ones_next[CW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ones_cnt_q <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// NRZI line encoder with bit stuffing and configurable EOP, driving registered D+/D-.
// Macro TX_LOW_SPEED_EN (see usb_tx_pkg) selects the J polarity.
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT  = DEF_STUFF_LIMIT,
  parameter int unsigned EOP_SE0_BITS = DEF_EOP_SE0_BITS,
  parameter int unsigned EOP_J_BITS   = DEF_EOP_J_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic shift_enable,
  input  logic bit_valid,
  input  logic serial_in,
  input  logic eop_req,
  input  logic reset_out,
  output logic ready,
  output logic Dplus_out,
  output logic Dminus_out,
  output logic tx_active,
  output logic packet_done
);

  localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_BITS);
  localparam logic [2:0] J_LAST   = 3'(EOP_J_BITS);

  tx_enc_state_t state_q, state_d;
  logic [2:0]    eop_cnt_q, eop_cnt_d;
  logic          dplus_q, dplus_d;
  logic          dminus_q, dminus_d;
  logic          tx_active_q, tx_active_d;
  logic          packet_done_q, packet_done_d;

  logic          accept_bit;
  logic          one_accept;
  logic          cnt_clr;
  logic          stuff_req;

  usb_tx_bit_stuffer #(
    .STUFF_LIMIT (STUFF_LIMIT)
  ) u_stuffer (
    .clk        (clk),
    .n_rst      (n_rst),
    .one_accept (one_accept),
    .clear      (cnt_clr),
    .stuff_req  (stuff_req)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      eop_cnt_q     <= '0;
      dplus_q       <= J_DP;
      dminus_q      <= J_DM;
      tx_active_q   <= 1'b0;
      packet_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      eop_cnt_q     <= eop_cnt_d;
      dplus_q       <= dplus_d;
      dminus_q      <= dminus_d;
      tx_active_q   <= tx_active_d;
      packet_done_q <= packet_done_d;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    eop_cnt_d     = eop_cnt_q;
    dplus_d       = dplus_q;
    dminus_d      = dminus_q;
    tx_active_d   = tx_active_q;
    packet_done_d = 1'b0;
    accept_bit    = 1'b0;
    one_accept    = 1'b0;
    cnt_clr       = 1'b0;

    if (reset_out) begin
      state_d     = IDLE;
      eop_cnt_d   = '0;
      dplus_d     = J_DP;
      dminus_d    = J_DM;
      tx_active_d = 1'b0;
      cnt_clr     = 1'b1;
    end else if (shift_enable) begin
      unique case (state_q)
        IDLE: begin
          if (bit_valid && !eop_req) begin
            accept_bit  = 1'b1;
            tx_active_d = 1'b1;
          end
        end
        DATA: begin
          if (eop_req) begin
            dplus_d   = SE0_DP;
            dminus_d  = SE0_DM;
            eop_cnt_d = 3'd1;
            cnt_clr   = 1'b1;
            state_d   = EOP_SE0;
          end else if (bit_valid) begin
            accept_bit = 1'b1;
          end
        end
        STUFF: begin
          dplus_d  = ~dplus_q;
          dminus_d = ~dminus_q;
          cnt_clr  = 1'b1;
          state_d  = DATA;
        end
        EOP_SE0: begin
          if (eop_cnt_q == SE0_LAST) begin
            dplus_d   = J_DP;
            dminus_d  = J_DM;
            eop_cnt_d = 3'd1;
            state_d   = EOP_J;
          end else begin
            eop_cnt_d = eop_cnt_q + 3'd1;
          end
        end
        EOP_J: begin
          if (eop_cnt_q == J_LAST) begin
            eop_cnt_d     = '0;
            tx_active_d   = 1'b0;
            packet_done_d = 1'b1;
            state_d       = IDLE;
          end else begin
            eop_cnt_d = eop_cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      // A 0 is a transition; a 1 holds the line and may complete a stuffing run.
      if (accept_bit) begin
        state_d = DATA;
        if (serial_in) begin
          one_accept = 1'b1;
          if (stuff_req) begin
            state_d = STUFF;
          end
        end else begin
          dplus_d  = ~dplus_q;
          dminus_d = ~dminus_q;
          cnt_clr  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready = shift_enable & ((state_q == IDLE) | (state_q == DATA)) & ~reset_out;
  end

  assign Dplus_out   = dplus_q;
  assign Dminus_out  = dminus_q;
  assign tx_active   = tx_active_q;
  assign packet_done = packet_done_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Scoreboard bench: directed strobes push expected ready/line/status; a negedge monitor compares.
module tb_usb_tx_line_encoder;

`ifdef TX_LOW_SPEED_EN
  localparam logic [1:0] LJ = 2'b01;
`else
  localparam logic [1:0] LJ = 2'b10;
`endif
  localparam logic [1:0] LK = ~LJ;
  localparam logic [1:0] LS = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic shift_enable = 1'b0;
  logic bv0 = 1'b0, si0 = 1'b0, eop0 = 1'b0, ro0 = 1'b0;
  logic bv1 = 1'b0, si1 = 1'b0, eop1 = 1'b0, ro1 = 1'b0;
  logic rdy0, dp0, dm0, act0, pd0;
  logic rdy1, dp1, dm1, act1, pd1;

  always #5 clk = ~clk;

  usb_tx_line_encoder dut0 (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
    .bit_valid(bv0), .serial_in(si0), .eop_req(eop0), .reset_out(ro0),
    .ready(rdy0), .Dplus_out(dp0), .Dminus_out(dm0),
    .tx_active(act0), .packet_done(pd0)
  );

  usb_tx_line_encoder #(.EOP_SE0_BITS(3), .EOP_J_BITS(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
    .bit_valid(bv1), .serial_in(si1), .eop_req(eop1), .reset_out(ro1),
    .ready(rdy1), .Dplus_out(dp1), .Dminus_out(dm1),
    .tx_active(act1), .packet_done(pd1)
  );

  typedef struct {
    int         id;
    int         tag;
    logic       er;
    logic [1:0] el;
    logic       ea;
    logic       ep;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_no   = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vector %0d): got %0h expected %0h", name, tag, act, exp);
  endtask

  function automatic logic [1:0] line_of(input int id);
    return (id == 0) ? {dp0, dm0} : {dp1, dm1};
  endfunction
  function automatic logic ready_of(input int id);
    return (id == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic act_of(input int id);
    return (id == 0) ? act0 : act1;
  endfunction
  function automatic logic pd_of(input int id);
    return (id == 0) ? pd0 : pd1;
  endfunction

  // Monitor: ready at the strobe, line/status one clk later, then stability one clk after that.
  exp_t s1, s2;
  logic s1_v = 1'b0, s2_v = 1'b0;
  always @(negedge clk) begin
    if (s2_v) begin
      check("line_stable", s2.tag, 32'(line_of(s2.id)), 32'(s2.el));
      check("pd_one_clk", s2.tag, 32'(pd_of(s2.id)), 32'd0);
      s2_v = 1'b0;
    end
    if (s1_v) begin
      check("line", s1.tag, 32'(line_of(s1.id)), 32'(s1.el));
      check("tx_active", s1.tag, 32'(act_of(s1.id)), 32'(s1.ea));
      check("packet_done", s1.tag, 32'(pd_of(s1.id)), 32'(s1.ep));
      s2 = s1;
      s2_v = 1'b1;
      s1_v = 1'b0;
    end
    if (shift_enable) begin
      if (exp_q.size() == 0) begin
        check("strobe_without_expectation", -1, 32'd1, 32'd0);
      end else begin
        s1 = exp_q.pop_front();
        check("ready", s1.tag, 32'(ready_of(s1.id)), 32'(s1.er));
        s1_v = 1'b1;
      end
    end
  end

  task automatic strobe(input int id, input logic bv, input logic si, input logic eop, input logic ro,
                        input logic er, input logic [1:0] el, input logic ea, input logic ep);
    exp_t e;
    @(posedge clk); #1;
    if (id == 0) begin bv0 = bv; si0 = si; eop0 = eop; ro0 = ro; end
    else         begin bv1 = bv; si1 = si; eop1 = eop; ro1 = ro; end
    e.id = id; e.tag = vec_no; e.er = er; e.el = el; e.ea = ea; e.ep = ep;
    vec_no++;
    exp_q.push_back(e);
    shift_enable = 1'b1;
    @(posedge clk); #1;
    shift_enable = 1'b0;
    bv0 = 1'b0; si0 = 1'b0; eop0 = 1'b0; ro0 = 1'b0;
    bv1 = 1'b0; si1 = 1'b0; eop1 = 1'b0; ro1 = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_line0"}, -1, 32'({dp0, dm0}), 32'(LJ));
    check({name, "_act0"}, -1, 32'(act0), 32'd0);
    check({name, "_pd0"}, -1, 32'(pd0), 32'd0);
    check({name, "_line1"}, -1, 32'({dp1, dm1}), 32'(LJ));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    n_rst = 1'b1;

    // Drive the line to K, then reset for 2 clks: first clk in reset returns J.
    strobe(0, 1, 0, 0, 0, 1, LK, 1, 0);
    @(posedge clk); #1; n_rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("reset_from_k");
    @(posedge clk); #1; n_rst = 1'b1;

    // eop_req in IDLE is ignored, with or without bit_valid.
    strobe(0, 0, 0, 1, 0, 1, LJ, 0, 0);
    strobe(0, 1, 1, 1, 0, 1, LJ, 0, 0);

    // 8'h00: a transition on every strobe, then default EOP (2 SE0, 1 J).
    for (int i = 0; i < 8; i++) strobe(0, 1, 0, 0, 0, 1, (i % 2 == 0) ? LK : LJ, 1, 0);
    strobe(0, 0, 0, 1, 0, 1, LS, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LS, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LJ, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LJ, 0, 1);

    // 0 then seven 1s: stuff toggle stalls the 7th 1, which is taken on the following strobe.
    strobe(0, 1, 0, 0, 0, 1, LK, 1, 0);
    for (int i = 0; i < 6; i++) strobe(0, 1, 1, 0, 0, 1, LK, 1, 0);
    strobe(0, 1, 1, 0, 0, 0, LJ, 1, 0);
    strobe(0, 1, 1, 0, 0, 1, LJ, 1, 0);
    // Run restarts: 0, then six 1s complete a run right before eop_req.
    strobe(0, 1, 0, 0, 0, 1, LK, 1, 0);
    for (int i = 0; i < 6; i++) strobe(0, 1, 1, 0, 0, 1, LK, 1, 0);
    strobe(0, 0, 0, 1, 0, 0, LJ, 1, 0);
    strobe(0, 0, 0, 1, 0, 1, LS, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LS, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LJ, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LJ, 0, 1);

    // Abort during EOP_SE0: J at once, no packet_done, then a normal packet.
    strobe(0, 1, 0, 0, 0, 1, LK, 1, 0);
    strobe(0, 1, 0, 0, 0, 1, LJ, 1, 0);
    strobe(0, 0, 0, 1, 0, 1, LS, 1, 0);
    strobe(0, 0, 0, 0, 1, 0, LJ, 0, 0);
    strobe(0, 0, 0, 0, 0, 1, LJ, 0, 0);
    strobe(0, 0, 0, 0, 0, 1, LJ, 0, 0);
    strobe(0, 1, 0, 0, 0, 1, LK, 1, 0);
    strobe(0, 1, 1, 0, 0, 1, LK, 1, 0);
    strobe(0, 0, 0, 1, 0, 1, LS, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LS, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LJ, 1, 0);
    strobe(0, 0, 0, 0, 0, 0, LJ, 0, 1);

    // Longer EOP instance: 3 SE0 bit times, 2 J bit times.
    strobe(1, 1, 0, 0, 0, 1, LK, 1, 0);
    strobe(1, 1, 1, 0, 0, 1, LK, 1, 0);
    strobe(1, 0, 0, 1, 0, 1, LS, 1, 0);
    strobe(1, 0, 0, 0, 0, 0, LS, 1, 0);
    strobe(1, 0, 0, 0, 0, 0, LS, 1, 0);
    strobe(1, 0, 0, 0, 0, 0, LJ, 1, 0);
    strobe(1, 0, 0, 0, 0, 0, LJ, 1, 0);
    strobe(1, 0, 0, 0, 0, 0, LJ, 0, 1);
    // Back-to-back: new packet on the first strobe after packet_done.
    strobe(1, 1, 0, 0, 0, 1, LK, 1, 0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", -1, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
